booth_ppgen: RTL

- Pipelined radix-4 Booth encoder and partial-product generator for the 11x11 signed multiplier.
- Sits directly upstream of the Dadda compression tree and drives its 6x13-bit partial-product bus.
- Takes one operand pair per accepted transaction through a valid/ready handshake.
- Produces six recoded partial products plus per-row negate bits, two cycles later, with full backpressure support.

---
 rtl/booth_ppgen_if.sv | 25 ++
 rtl/booth_ppgen.sv | 129 ++++++++++++
 2 files changed

// File: rtl/booth_ppgen_if.sv
// Operand/partial-product handshake bundle between the operand source, booth_ppgen and the tree.
// master = operand source plus tree sink (drives in_* and out_ready); slave = booth_ppgen.
interface booth_ppgen_if #(
  parameter int unsigned N   = 11,
  parameter int unsigned NPP = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic [N-1:0]          a;
  logic [N-1:0]          b;
  logic                  out_valid;
  logic                  out_ready;
  logic [NPP-1:0][N+1:0] ops;
  logic [NPP-1:0]        neg;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, ops, neg
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, ops, neg
  );
endinterface

// File: rtl/booth_ppgen.sv
// Two-stage radix-4 Booth encoder / partial-product generator feeding the 11x11 Dadda tree.
// Optional accepted-transaction counter (acc_cnt) under macro BOOTH_PPGEN_PERF_CNT_EN.
module booth_ppgen #(
  parameter int unsigned N   = 11,
  parameter int unsigned NPP = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  booth_ppgen_if.slave bus
`ifdef BOOTH_PPGEN_PERF_CNT_EN
  ,
  output logic [15:0]  acc_cnt
`endif
);

  if (N != 11 || NPP != (N + 1) / 2) begin : g_bad_cfg
    $error("booth_ppgen: only N=11, NPP=6 are supported");
  end

  logic                  r_s1_valid;
  logic [N-1:0]          r_a;
  logic [N-1:0]          r_b;
  logic                  r_s2_valid;
  logic [NPP-1:0][N+1:0] r_ops;
  logic [NPP-1:0]        r_neg;

  logic                  w_s1_adv;
  logic                  w_s2_adv;
  logic                  w_accept;
  logic [N+1:0]          w_bx;
  logic [N:0]            w_a1;
  logic [N:0]            w_a2;
  logic [NPP-1:0][N+1:0] w_ops;
  logic [NPP-1:0]        w_neg;

  assign w_s2_adv     = !r_s2_valid || bus.out_ready;
  assign w_s1_adv     = !r_s1_valid || w_s2_adv;
  assign w_accept     = bus.in_valid && w_s1_adv;
  assign bus.in_ready = w_s1_adv;
  assign bus.out_valid = r_s2_valid;
  assign bus.ops       = r_ops;
  assign bus.neg       = r_neg;

  // b[-1]=0 on the right, b[N]=b[N-1] on the left; row i reads the triplet at bit 2i.
  assign w_bx = {r_b[N-1], r_b, 1'b0};
  assign w_a1 = {r_a[N-1], r_a};
  assign w_a2 = {r_a, 1'b0};

  for (genvar gi = 0; gi < NPP; gi++) begin : g_row
    logic [2:0] w_trip;
    logic [N:0] w_m;
    logic       w_n;
    logic [N:0] w_pp;

    assign w_trip = w_bx[2*gi +: 3];

    always_comb begin
      w_m = '0;
      w_n = 1'b0;
      unique case (w_trip)
        3'b001, 3'b010: w_m = w_a1;
        3'b011:         w_m = w_a2;
        3'b100: begin
          w_m = w_a2;
          w_n = 1'b1;
        end
        3'b101, 3'b110: begin
          w_m = w_a1;
          w_n = 1'b1;
        end
        default: begin
          w_m = '0;
          w_n = 1'b0;
        end
      endcase
    end

    // Inverted sign bit lets the tree skip sign extension of each row.
    assign w_pp        = w_n ? ~w_m : w_m;
    assign w_ops[gi]   = {~w_pp[N], w_pp};
    assign w_neg[gi]   = w_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_a <= bus.a;
        r_b <= bus.b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_ops      <= '0;
      r_neg      <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_ops <= w_ops;
        r_neg <= w_neg;
      end
    end
  end

`ifdef BOOTH_PPGEN_PERF_CNT_EN
  logic [15:0] r_acc_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_cnt <= '0;
    end else if (w_accept && (r_acc_cnt != 16'hFFFF)) begin
      r_acc_cnt <= r_acc_cnt + 16'd1;
    end
  end

  assign acc_cnt = r_acc_cnt;
`else
  logic w_unused_accept;
  assign w_unused_accept = w_accept;
`endif

endmodule
